// File: rtl/store_write_buffer_if.sv
// Store-side, load-probe and memory-write signals of the store write buffer.
// The buffer connects as slave; the core / memory environment connects as master.
interface store_write_buffer_if;
  logic        st_valid;
  logic [2:0]  st_func3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_error;
  logic        ld_check_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteen;
  logic        mem_busywait;
  logic        empty;
  logic [3:0]  count;

  modport master (
    output st_valid, st_func3, st_addr, st_data, ld_check_valid, ld_addr, mem_busywait,
    input  st_ready, st_error, ld_hazard, mem_write, mem_addr, mem_writedata, mem_byteen,
           empty, count
  );

  modport slave (
    input  st_valid, st_func3, st_addr, st_data, ld_check_valid, ld_addr, mem_busywait,
    output st_ready, st_error, ld_hazard, mem_write, mem_addr, mem_writedata, mem_byteen,
           empty, count
  );
endinterface

// File: rtl/store_write_buffer.sv
// FIFO of lane-positioned stores drained to data memory one write at a time,
// with a word-granular load hazard probe over every held entry.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  logic [29:0] ent_addr [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [3:0]  ent_be   [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [3:0]  count;
  logic        legal, push, pop, reject, hazard, ready;
  logic [4:0]  shamt;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;
  logic        mem_write_q, st_error_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  // Legality check and lane placement of the offered store.
  always_comb begin
    shamt    = {bus.st_addr[1:0], 3'b000};
    legal    = 1'b0;
    fmt_data = '0;
    fmt_be   = '0;
    case (bus.st_func3)
      3'b000: begin
        legal    = 1'b1;
        fmt_data = {24'd0, bus.st_data[7:0]} << shamt;
        fmt_be   = 4'b0001 << bus.st_addr[1:0];
      end
      3'b001: begin
        legal    = ~bus.st_addr[0];
        fmt_data = {16'd0, bus.st_data[15:0]} << shamt;
        fmt_be   = 4'b0011 << bus.st_addr[1:0];
      end
      3'b010: begin
        legal    = (bus.st_addr[1:0] == 2'b00);
        fmt_data = bus.st_data;
        fmt_be   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign ready   = (count < DEPTH_C);
  assign push    = bus.st_valid & ready & legal;
  assign reject  = bus.st_valid & ready & ~legal;
  assign pop     = (state == WRITE) & ~bus.mem_busywait;
  assign rd_next = rd_ptr + PW'(1);

  // Entry storage; push and pop never address the same slot since push needs a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[wr_ptr] <= bus.st_addr[31:2];
        ent_data[wr_ptr] <= fmt_data;
        ent_be[wr_ptr]   <= fmt_be;
        valid[wr_ptr]    <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_next;
      end
      count <= count + {3'b000, push} - {3'b000, pop};
    end
  end

  // Drain FSM; a lone remaining entry pushed on the completion edge is taken straight from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      st_error_q  <= 1'b0;
    end else begin
      st_error_q <= reject;
      case (state)
        IDLE: begin
          if (count != 4'd0) begin
            state       <= WRITE;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {ent_addr[rd_ptr], 2'b00};
            mem_wdata_q <= ent_data[rd_ptr];
            mem_be_q    <= ent_be[rd_ptr];
          end
        end
        WRITE: begin
          if (!bus.mem_busywait) begin
            if (count > 4'd1) begin
              mem_addr_q  <= {ent_addr[rd_next], 2'b00};
              mem_wdata_q <= ent_data[rd_next];
              mem_be_q    <= ent_be[rd_next];
            end else if (push) begin
              mem_addr_q  <= {bus.st_addr[31:2], 2'b00};
              mem_wdata_q <= fmt_data;
              mem_be_q    <= fmt_be;
            end else begin
              state       <= IDLE;
              mem_write_q <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
              mem_be_q    <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (ent_addr[i] == bus.ld_addr[31:2])) hazard = 1'b1;
    end
  end

  assign bus.ld_hazard     = bus.ld_check_valid & hazard;
  assign bus.st_ready      = ready;
  assign bus.st_error      = st_error_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_writedata = mem_wdata_q;
  assign bus.mem_byteen    = mem_be_q;
  assign bus.count         = count;
  assign bus.empty         = (count == 4'd0);
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random traffic
// compared against a queue-based model of pending stores and the write in flight.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam logic [75:0] RESET_VIEW = 76'h3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  wr_t  q[$];
  logic mInflight;
  wr_t  mOut;
  logic mErr;

  store_write_buffer_if bus();

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic isLegal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0: return 1'b1;
      3'd1: return (a % 2) == 0;
      3'd2: return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic wr_t expectedWrite(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d);
    wr_t w;
    int  lane;
    lane   = int'(a % 4);
    w      = '0;
    w.addr = a - 32'(lane);
    case (f3)
      3'd0: begin
        w.data = (d & 32'hFF) * (32'd1 << (8 * lane));
        w.be   = 4'(1 << lane);
      end
      3'd1: begin
        w.data = (d & 32'hFFFF) * (32'd1 << (8 * lane));
        w.be   = 4'(3 << lane);
      end
      3'd2: begin
        w.data = d;
        w.be   = 4'hF;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [75:0] modelView();
    return {mInflight, mOut, 4'(q.size()), mErr, (q.size() < DEPTH), (q.size() == 0)};
  endfunction

  function automatic logic [75:0] dutView();
    return {bus.mem_write, bus.mem_addr, bus.mem_writedata, bus.mem_byteen,
            bus.count, bus.st_error, bus.st_ready, bus.empty};
  endfunction

  function automatic logic modelHazard(input logic [31:0] la);
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    q.delete();
    mInflight = 1'b0;
    mOut      = '0;
    mErr      = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model by the same edge.
  task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input logic busy,
                               input logic lv, input logic [31:0] la);
    logic accept, reject;
    wr_t  w;
    bus.st_valid       = v;
    bus.st_func3       = f3;
    bus.st_addr        = a;
    bus.st_data        = d;
    bus.mem_busywait   = busy;
    bus.ld_check_valid = lv;
    bus.ld_addr        = la;
    accept = v && (q.size() < DEPTH) && isLegal(f3, a);
    reject = v && (q.size() < DEPTH) && !isLegal(f3, a);
    w      = expectedWrite(f3, a, d);
    @(posedge clk);
    if (mInflight) begin
      if (!busy) begin
        void'(q.pop_front());
        if (accept) q.push_back(w);
        if (q.size() > 0) mOut = q[0];
        else begin
          mInflight = 1'b0;
          mOut      = '0;
        end
      end else if (accept) q.push_back(w);
    end else begin
      if (q.size() > 0) begin
        mInflight = 1'b1;
        mOut      = q[0];
      end
      if (accept) q.push_back(w);
    end
    mErr = reject;
    #1;
  endtask

  task automatic idleCycle(input logic busy);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, busy, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.st_valid = 1'b0; bus.st_func3 = 3'd0; bus.st_addr = '0; bus.st_data = '0;
    bus.mem_busywait = 1'b0; bus.ld_check_valid = 1'b1; bus.ld_addr = '0;
    #3;
    modelReset();
    vectors++;
    if (dutView() !== RESET_VIEW) begin
      miscompares++;
      $display("[TB] FAIL reset_view got=%h exp=%h", dutView(), RESET_VIEW);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.ld_hazard !== 1'b0 || dutView() !== RESET_VIEW) begin
      miscompares++;
      $display("[TB] FAIL reset_held got=%h/%b exp=%h/0", dutView(), bus.ld_hazard, RESET_VIEW);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ld_check_valid = 1'b0;
  endtask

  task automatic test_byte_store();
    applyStimulus(1'b1, 3'd0, 32'h1003, 32'hAB, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (dutView() !== modelView()) begin
      miscompares++;
      $display("[TB] FAIL sb_accept got=%h exp=%h", dutView(), modelView());
    end
    idleCycle(1'b0);
    vectors++;
    if ({bus.mem_write, bus.mem_addr, bus.mem_byteen, bus.mem_writedata} !==
        {1'b1, 32'h1000, 4'b1000, 32'hAB000000}) begin
      miscompares++;
      $display("[TB] FAIL sb_write got=%b %h %b %h exp=1 00001000 1000 ab000000",
               bus.mem_write, bus.mem_addr, bus.mem_byteen, bus.mem_writedata);
    end
    idleCycle(1'b0);
    vectors++;
    if (bus.empty !== 1'b1 || bus.mem_write !== 1'b0 || dutView() !== modelView()) begin
      miscompares++;
      $display("[TB] FAIL sb_drained got=%h exp=%h", dutView(), modelView());
    end
  endtask

  task automatic test_half_store();
    applyStimulus(1'b1, 3'd1, 32'h2002, 32'h1234, 1'b0, 1'b0, 32'd0);
    idleCycle(1'b0);
    vectors++;
    if ({bus.mem_write, bus.mem_addr, bus.mem_byteen, bus.mem_writedata} !==
        {1'b1, 32'h2000, 4'b1100, 32'h12340000}) begin
      miscompares++;
      $display("[TB] FAIL sh_write got=%b %h %b %h exp=1 00002000 1100 12340000",
               bus.mem_write, bus.mem_addr, bus.mem_byteen, bus.mem_writedata);
    end
    idleCycle(1'b0);
    applyStimulus(1'b1, 3'd1, 32'h2001, 32'h1234, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.st_error !== 1'b1 || bus.count !== 4'd0 || dutView() !== modelView()) begin
      miscompares++;
      $display("[TB] FAIL sh_misaligned got=%h exp=%h", dutView(), modelView());
    end
    idleCycle(1'b0);
    vectors++;
    if (bus.st_error !== 1'b0 || bus.mem_write !== 1'b0 || bus.count !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL sh_error_pulse got err=%b wr=%b cnt=%0d exp err=0 wr=0 cnt=0",
               bus.st_error, bus.mem_write, bus.count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'd2, 32'h4000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1,
                    1'b0, 32'd0);
      vectors++;
      if (dutView() !== modelView()) begin
        miscompares++;
        $display("[TB] FAIL full_push%0d got=%h exp=%h", i, dutView(), modelView());
      end
    end
    vectors++;
    if (bus.st_ready !== 1'b0 || bus.count !== 4'd4 || bus.mem_addr !== 32'h4000) begin
      miscompares++;
      $display("[TB] FAIL full_state got rdy=%b cnt=%0d addr=%h exp rdy=0 cnt=4 addr=00004000",
               bus.st_ready, bus.count, bus.mem_addr);
    end
    for (int k = 1; k <= 4; k++) begin
      idleCycle(1'b0);
      vectors++;
      if (k < 4 ? (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h4000 + 32'(4 * k))
                : (bus.mem_write !== 1'b0 || bus.empty !== 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL full_drain%0d got wr=%b addr=%h empty=%b", k, bus.mem_write,
                 bus.mem_addr, bus.empty);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 3'd2, 32'h5000, 32'h11111111, 1'b1, 1'b0, 32'd0);
    idleCycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle(1'b1);
      vectors++;
      if ({bus.mem_write, bus.mem_addr, bus.mem_writedata, bus.mem_byteen} !==
          {1'b1, 32'h5000, 32'h11111111, 4'hF}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d got=%b %h %h %b", i, bus.mem_write, bus.mem_addr,
                 bus.mem_writedata, bus.mem_byteen);
      end
    end
    applyStimulus(1'b1, 3'd2, 32'h5004, 32'h22222222, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (bus.count !== 4'd1 || bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h5004 ||
        bus.mem_writedata !== 32'h22222222 || dutView() !== modelView()) begin
      miscompares++;
      $display("[TB] FAIL push_on_complete got=%h exp=%h", dutView(), modelView());
    end
    idleCycle(1'b0);
  endtask

  task automatic test_hazard();
    applyStimulus(1'b1, 3'd2, 32'h3008, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    idleCycle(1'b1);
    bus.ld_check_valid = 1'b1; bus.ld_addr = 32'h300B; #1;
    vectors++;
    if (bus.ld_hazard !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hazard_hit got=%b exp=1", bus.ld_hazard);
    end
    bus.ld_addr = 32'h300C;
    bus.st_valid = 1'b1; bus.st_func3 = 3'd2; bus.st_addr = 32'h300C; #1;
    vectors++;
    if (bus.ld_hazard !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hazard_other_word got=%b exp=0", bus.ld_hazard);
    end
    bus.st_valid = 1'b0; bus.ld_check_valid = 1'b0; bus.ld_addr = 32'h3008; #1;
    vectors++;
    if (bus.ld_hazard !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hazard_no_probe got=%b exp=0", bus.ld_hazard);
    end
    idleCycle(1'b0);
    bus.ld_check_valid = 1'b1; bus.ld_addr = 32'h300B; #1;
    vectors++;
    if (bus.ld_hazard !== 1'b0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hazard_after_drain got=%b empty=%b exp=0 1", bus.ld_hazard, bus.empty);
    end
    bus.ld_check_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 3'd2, 32'h7000 + 32'(4 * i), 32'h7700 + 32'(i), 1'b1, 1'b0, 32'd0);
    idleCycle(1'b1);
    vectors++;
    if (bus.count !== 4'd3 || bus.mem_write !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_setup got cnt=%0d wr=%b exp cnt=3 wr=1", bus.count, bus.mem_write);
    end
    #2 rst = 1'b1;
    bus.ld_check_valid = 1'b1; bus.ld_addr = 32'h7000;
    #1;
    modelReset();
    vectors++;
    if (dutView() !== RESET_VIEW || bus.ld_hazard !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_write got=%h/%b exp=%h/0", dutView(), bus.ld_hazard, RESET_VIEW);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idleCycle(1'b0);
      vectors++;
      if (bus.mem_write !== 1'b0 || bus.count !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL rst_no_reissue%0d got wr=%b cnt=%0d exp wr=0 cnt=0", i,
                 bus.mem_write, bus.count);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, la;
    logic        expHazard;
    for (int n = 0; n < 400; n++) begin
      f3 = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = 32'h6000 + 32'($urandom_range(0, 15));
      la = 32'h6000 + 32'($urandom_range(0, 19));
      applyStimulus($urandom_range(0, 2) != 0, f3, a, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, la);
      vectors++;
      if (dutView() !== modelView()) begin
        miscompares++;
        $display("[TB] FAIL random_view%0d got=%h exp=%h", n, dutView(), modelView());
      end
      expHazard = bus.ld_check_valid && modelHazard(la);
      vectors++;
      if (bus.ld_hazard !== expHazard) begin
        miscompares++;
        $display("[TB] FAIL random_hazard%0d got=%b exp=%b", n, bus.ld_hazard, expHazard);
      end
    end
    for (int n = 0; n < 8; n++) idleCycle(1'b0);
    vectors++;
    if (dutView() !== modelView() || bus.empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL random_final got=%h exp=%h", dutView(), modelView());
    end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_store();
    test_full();
    test_back_to_back();
    test_hazard();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of buffered store entries (power of two, 2..8).
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 st_valid  input  1  a store request is present this cycle.
REQ-005 st_func3  input  3  store width: 000 byte, 001 half, 010 word.
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_data  input  32  store data, low-justified and zero-extended by the store-data stage.
REQ-008 st_ready  output  1  the buffer can accept a store this cycle.
REQ-009 st_error  output  1  one-cycle pulse marking a rejected misaligned or illegal store.
REQ-010 ld_check_valid  input  1  a load is probing for a hazard.
REQ-011 ld_addr  input  32  byte address of the probing load.
REQ-012 ld_hazard  output  1  the load word overlaps a pending store.
REQ-013 mem_write  output  1  write request to data memory.
REQ-014 mem_addr  output  32  word-aligned write address, bits [1:0] = 00.
REQ-015 mem_writedata  output  32  lane-positioned write data.
REQ-016 mem_byteen  output  4  byte enables, bit i = byte lane i.
REQ-017 mem_busywait  input  1  memory not yet done with the current write.
REQ-018 empty  output  1  no entries held; count  output  4  entries held, 0..DEPTH.

Function
REQ-019 A store SHALL be accepted at a rising edge when st_valid=1, st_ready=1 and the store is legal.
REQ-020 st_ready SHALL be 1 exactly when count < DEPTH; a pop in the same cycle SHALL NOT raise st_ready.
REQ-021 Byte store: byteen = 0001 << addr[1:0]; data = st_data[7:0] << 8*addr[1:0]; all other bits are 0.
REQ-022 Half store: legal only if addr[0]=0; byteen = 0011 << addr[1:0]; data = st_data[15:0] << 8*addr[1:0].
REQ-023 Word store: legal only if addr[1:0]=00; byteen = 1111; data = st_data.
REQ-024 A misaligned store or any other func3 with st_valid=1 and st_ready=1 SHALL NOT enqueue, and SHALL assert st_error for the following cycle only.
REQ-025 Each entry SHALL hold {addr[31:2], data, byteen}; entries SHALL drain strictly in FIFO order, with pointers wrapping modulo DEPTH.
REQ-026 The drain FSM SHALL have two states, IDLE and WRITE.
REQ-027 IDLE: when count>0, the FSM SHALL go to WRITE at the next edge and load mem_addr, mem_writedata and mem_byteen from the head entry while setting mem_write=1.
REQ-028 WRITE: mem_* outputs SHALL hold stable while mem_busywait=1.
REQ-029 A write SHALL complete at an edge where mem_write=1 and mem_busywait=0; the head SHALL then pop.
REQ-030 On completion, if entries remain (including one pushed that same edge), the FSM SHALL stay in WRITE and load the next head, giving back-to-back writes.
REQ-031 On completion with no entries remaining, the FSM SHALL return to IDLE and clear mem_write, mem_byteen and mem_writedata to 0.
REQ-032 On a simultaneous push and pop, count SHALL be unchanged; otherwise count SHALL change by exactly ±1.
REQ-033 ld_hazard SHALL be combinational: 1 when ld_check_valid=1 and any held entry, including the in-flight head, has addr[31:2] = ld_addr[31:2].
REQ-034 A store being offered in the same cycle SHALL NOT count toward ld_hazard.
REQ-035 Minimum latency SHALL be one cycle: a store accepted at edge N into an empty IDLE buffer drives mem_write=1 after edge N+1.

Reset
REQ-036 While RESET=1, regardless of CLK, the block SHALL force: state IDLE, count 0, pointers 0, all entries invalid, mem_write 0, mem_addr 0, mem_writedata 0, mem_byteen 0, st_error 0, empty 1, st_ready 1, ld_hazard 0.
REQ-037 Reset during WRITE SHALL abandon the in-flight write and discard all pending entries; no write SHALL be reissued afterward.

Verification
REQ-038 sb, addr 0x1003, data 0x000000AB, busywait 0 -> one cycle later: mem_write=1, mem_addr 0x1000, mem_byteen 1000, mem_writedata 0xAB000000; the next cycle empty=1.
REQ-039 sh at 0x2002, data 0x1234 -> mem_byteen 1100, mem_writedata 0x12340000; sh at 0x2001 -> st_error pulse, count unchanged, no mem_write.
REQ-040 Five sw pushed while busywait=1 with DEPTH=4 -> st_ready=0 after the fourth; the fifth is not accepted. Release busywait -> four writes complete in order, one per cycle.
REQ-041 Hold busywait=1 for 3 cycles during a write -> mem_* stable throughout. A push on the completion edge -> count unchanged and the next write starts immediately.
REQ-042 Pending sw at 0x3008; load probe 0x300B -> ld_hazard=1; probe 0x300C -> 0. After the write drains, probe 0x300B -> 0.
REQ-043 Assert RESET mid-WRITE with 3 entries held -> outputs take the REQ-036 values immediately, and no further mem_write occurs after release.
